// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ALU instructions until both operands arrive on the ALU/LSB CDBs
// and issues one ready entry per cycle. Define RS_ISSUE_OLDEST_EN for oldest-first issue (default: lowest index).
module reservation_station #(
    parameter int RS_SIZE   = 8,
    parameter int ROB_TAG_W = 4,
    parameter int INST_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_in,
    input  logic                 new_inst_signal_in,
    input  logic [INST_W-1:0]    inst_in,
    input  logic [31:0]          imm_in,
    input  logic [31:0]          pc_in,
    input  logic [ROB_TAG_W-1:0] dest_in,
    input  logic                 rs1_busy_in,
    input  logic [ROB_TAG_W-1:0] rs1_tag_in,
    input  logic [31:0]          rs1_val_in,
    input  logic                 rs2_busy_in,
    input  logic [ROB_TAG_W-1:0] rs2_tag_in,
    input  logic [31:0]          rs2_val_in,
    input  logic                 alu_cdb_valid_in,
    input  logic [ROB_TAG_W-1:0] alu_cdb_tag_in,
    input  logic [31:0]          alu_cdb_val_in,
    input  logic                 lsb_cdb_valid_in,
    input  logic [ROB_TAG_W-1:0] lsb_cdb_tag_in,
    input  logic [31:0]          lsb_cdb_val_in,
    output logic                 full_out,
    output logic                 alu_valid_out,
    output logic [INST_W-1:0]    alu_inst_out,
    output logic [31:0]          alu_v1_out,
    output logic [31:0]          alu_v2_out,
    output logic [31:0]          alu_imm_out,
    output logic [31:0]          alu_pc_out,
    output logic [ROB_TAG_W-1:0] alu_dest_out
);

    localparam int IDX_W = $clog2(RS_SIZE);
`ifdef RS_ISSUE_OLDEST_EN
    localparam int AGE_W = $clog2(RS_SIZE) + 1;
`endif

    // Returns {still_pending, value}; ALU bus wins if both buses carry the awaited tag.
    function automatic logic [32:0] snoop(input logic pend, input logic [ROB_TAG_W-1:0] tag,
                                          input logic [31:0] val);
        logic [32:0] r;
        r = {pend, val};
        if (pend) begin
            if (alu_cdb_valid_in && alu_cdb_tag_in == tag)
                r = {1'b0, alu_cdb_val_in};
            else if (lsb_cdb_valid_in && lsb_cdb_tag_in == tag)
                r = {1'b0, lsb_cdb_val_in};
        end
        return r;
    endfunction

    logic [RS_SIZE-1:0]   busy_w;
    logic [RS_SIZE-1:0]   ready_w;
    logic [INST_W-1:0]    inst_w [RS_SIZE];
    logic [31:0]          imm_w  [RS_SIZE];
    logic [31:0]          pc_w   [RS_SIZE];
    logic [ROB_TAG_W-1:0] dest_w [RS_SIZE];
    logic [31:0]          vj_w   [RS_SIZE];
    logic [31:0]          vk_w   [RS_SIZE];
`ifdef RS_ISSUE_OLDEST_EN
    logic [AGE_W-1:0]     age_w  [RS_SIZE];
`endif

    logic             dispatch_en;
    logic [IDX_W-1:0] free_idx;
    logic             disp_j_pend;
    logic             disp_k_pend;
    logic [31:0]      disp_vj;
    logic [31:0]      disp_vk;
    logic             issue_found;
    logic [IDX_W-1:0] issue_idx;

    assign full_out    = &busy_w;
    assign dispatch_en = new_inst_signal_in && !full_out && !clear_in;

    always_comb begin
        {disp_j_pend, disp_vj} = snoop(rs1_busy_in, rs1_tag_in, rs1_val_in);
        {disp_k_pend, disp_vk} = snoop(rs2_busy_in, rs2_tag_in, rs2_val_in);
    end

    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_w[i])
                free_idx = IDX_W'(i);
        end
    end

`ifdef RS_ISSUE_OLDEST_EN
    logic [AGE_W-1:0] best_age;

    // Strict greater-than keeps the lowest index on equal ages.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        best_age    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready_w[i] && (!issue_found || age_w[i] > best_age)) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
                best_age    = age_w[i];
            end
        end
    end
`else
    always_comb begin
        issue_found = |ready_w;
        issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready_w[i])
                issue_idx = IDX_W'(i);
        end
    end
`endif

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
        logic                 busy_q, busy_d;
        logic [INST_W-1:0]    inst_q, inst_d;
        logic [31:0]          imm_q, imm_d;
        logic [31:0]          pc_q, pc_d;
        logic [ROB_TAG_W-1:0] dest_q, dest_d;
        logic [31:0]          vj_q, vj_d;
        logic [31:0]          vk_q, vk_d;
        logic [ROB_TAG_W-1:0] qj_q, qj_d;
        logic [ROB_TAG_W-1:0] qk_q, qk_d;
        logic                 qj_pend_q, qj_pend_d;
        logic                 qk_pend_q, qk_pend_d;
        logic                 alloc;
        logic                 issue_me;
        logic [32:0]          wake_j;
        logic [32:0]          wake_k;

        assign alloc    = dispatch_en && free_idx == IDX_W'(gi);
        assign issue_me = issue_found && issue_idx == IDX_W'(gi);
        assign wake_j   = snoop(qj_pend_q, qj_q, vj_q);
        assign wake_k   = snoop(qk_pend_q, qk_q, vk_q);

        always_comb begin
            busy_d    = busy_q;
            inst_d    = inst_q;
            imm_d     = imm_q;
            pc_d      = pc_q;
            dest_d    = dest_q;
            vj_d      = vj_q;
            vk_d      = vk_q;
            qj_d      = qj_q;
            qk_d      = qk_q;
            qj_pend_d = qj_pend_q;
            qk_pend_d = qk_pend_q;
            if (clear_in) begin
                busy_d = 1'b0;
            end else if (alloc) begin
                busy_d    = 1'b1;
                inst_d    = inst_in;
                imm_d     = imm_in;
                pc_d      = pc_in;
                dest_d    = dest_in;
                qj_d      = rs1_tag_in;
                qk_d      = rs2_tag_in;
                qj_pend_d = disp_j_pend;
                qk_pend_d = disp_k_pend;
                vj_d      = disp_vj;
                vk_d      = disp_vk;
            end else if (busy_q) begin
                if (issue_me) begin
                    busy_d = 1'b0;
                end else begin
                    {qj_pend_d, vj_d} = wake_j;
                    {qk_pend_d, vk_d} = wake_k;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                busy_q    <= 1'b0;
                inst_q    <= '0;
                imm_q     <= '0;
                pc_q      <= '0;
                dest_q    <= '0;
                vj_q      <= '0;
                vk_q      <= '0;
                qj_q      <= '0;
                qk_q      <= '0;
                qj_pend_q <= 1'b0;
                qk_pend_q <= 1'b0;
            end else begin
                busy_q    <= busy_d;
                inst_q    <= inst_d;
                imm_q     <= imm_d;
                pc_q      <= pc_d;
                dest_q    <= dest_d;
                vj_q      <= vj_d;
                vk_q      <= vk_d;
                qj_q      <= qj_d;
                qk_q      <= qk_d;
                qj_pend_q <= qj_pend_d;
                qk_pend_q <= qk_pend_d;
            end
        end

`ifdef RS_ISSUE_OLDEST_EN
        logic [AGE_W-1:0] age_q, age_d;

        always_comb begin
            age_d = age_q;
            if (alloc)
                age_d = '0;
            else if (busy_q && !issue_me && age_q != {AGE_W{1'b1}})
                age_d = age_q + 1'b1;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                age_q <= '0;
            else
                age_q <= age_d;
        end

        assign age_w[gi] = age_q;
`endif

        assign busy_w[gi]  = busy_q;
        assign ready_w[gi] = busy_q && !qj_pend_q && !qk_pend_q;
        assign inst_w[gi]  = inst_q;
        assign imm_w[gi]   = imm_q;
        assign pc_w[gi]    = pc_q;
        assign dest_w[gi]  = dest_q;
        assign vj_w[gi]    = vj_q;
        assign vk_w[gi]    = vk_q;
    end

    logic                 alu_valid_q, alu_valid_d;
    logic [INST_W-1:0]    alu_inst_q, alu_inst_d;
    logic [31:0]          alu_v1_q, alu_v1_d;
    logic [31:0]          alu_v2_q, alu_v2_d;
    logic [31:0]          alu_imm_q, alu_imm_d;
    logic [31:0]          alu_pc_q, alu_pc_d;
    logic [ROB_TAG_W-1:0] alu_dest_q, alu_dest_d;

    // Data outputs hold between issues; only the strobe drops.
    always_comb begin
        alu_valid_d = 1'b0;
        alu_inst_d  = alu_inst_q;
        alu_v1_d    = alu_v1_q;
        alu_v2_d    = alu_v2_q;
        alu_imm_d   = alu_imm_q;
        alu_pc_d    = alu_pc_q;
        alu_dest_d  = alu_dest_q;
        if (!clear_in && issue_found) begin
            alu_valid_d = 1'b1;
            alu_inst_d  = inst_w[issue_idx];
            alu_v1_d    = vj_w[issue_idx];
            alu_v2_d    = vk_w[issue_idx];
            alu_imm_d   = imm_w[issue_idx];
            alu_pc_d    = pc_w[issue_idx];
            alu_dest_d  = dest_w[issue_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_valid_q <= 1'b0;
            alu_inst_q  <= '0;
            alu_v1_q    <= '0;
            alu_v2_q    <= '0;
            alu_imm_q   <= '0;
            alu_pc_q    <= '0;
            alu_dest_q  <= '0;
        end else begin
            alu_valid_q <= alu_valid_d;
            alu_inst_q  <= alu_inst_d;
            alu_v1_q    <= alu_v1_d;
            alu_v2_q    <= alu_v2_d;
            alu_imm_q   <= alu_imm_d;
            alu_pc_q    <= alu_pc_d;
            alu_dest_q  <= alu_dest_d;
        end
    end

    assign alu_valid_out = alu_valid_q;
    assign alu_inst_out  = alu_inst_q;
    assign alu_v1_out    = alu_v1_q;
    assign alu_v2_out    = alu_v2_q;
    assign alu_imm_out   = alu_imm_q;
    assign alu_pc_out    = alu_pc_q;
    assign alu_dest_out  = alu_dest_q;

endmodule
